qos_csr_bank: RTL and testbench

Parametrised control/status register bank for the MPEG2-TS QoS controller, replacing the fixed 4-channel, 3-register map. It sits between the host memory-mapped bus and main_control, and drives channel-selection configuration (fallback, manual override, priority, reset timer). It also mirrors live status, latches per-channel error-count snapshots, and raises a maskable interrupt on signal loss or active-channel change.

---
 rtl/qos_csr_bank.sv | 213 +++++++++++++++++++++
 tb/tb_qos_csr_bank.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qos_csr_bank.sv
// Host-facing CSR bank for the MPEG2-TS QoS controller: channel-selection config,
// live status mirrors, error-count snapshots and a maskable loss/channel-change interrupt.
module qos_csr_bank #(
  parameter int          N_CH    = 4,
  parameter int          CNT_W   = 8,
  parameter int          TIMER_W = 20,
  parameter logic [31:0] VERSION = 32'h0002_0000,
  localparam int         CHW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mm_write_en,
  input  logic                  mm_read_en,
  input  logic [7:0]            mm_addr,
  input  logic [31:0]           mm_wdata,
  output logic [31:0]           mm_rdata,
  output logic                  mm_rvalid,
  output logic                  mm_err,
  output logic                  fallback_enable,
  output logic                  manual_enable,
  output logic [CHW-1:0]        manual_channel,
  output logic [N_CH*CHW-1:0]   channel_priority,
  output logic [TIMER_W-1:0]    reset_timer,
  output logic                  irq,
  input  logic [CHW-1:0]        active_channel,
  input  logic [N_CH-1:0]       signal_present,
  input  logic [N_CH*CNT_W-1:0] error_count
);

  localparam logic [7:0] ADDR_CTRL    = 8'h00;
  localparam logic [7:0] ADDR_PRIO    = 8'h01;
  localparam logic [7:0] ADDR_TIMER   = 8'h02;
  localparam logic [7:0] ADDR_STATUS  = 8'h03;
  localparam logic [7:0] ADDR_IRQ_ST  = 8'h04;
  localparam logic [7:0] ADDR_IRQ_MSK = 8'h05;
  localparam logic [7:0] ADDR_SCRATCH = 8'h06;
  localparam logic [7:0] ADDR_VERSION = 8'h07;
  localparam logic [7:0] ADDR_CMD     = 8'h08;

  logic                fallback_q, fallback_d;
  logic                manual_q, manual_d;
  logic [CHW-1:0]      mchan_q, mchan_d;
  logic [N_CH*CHW-1:0] prio_q, prio_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [N_CH-1:0]     sp_q, sp_d;
  logic [CHW-1:0]      ac_q, ac_d;
  logic                armed_q, armed_d;
  logic [N_CH-1:0]     loss_q, loss_d;
  logic                chg_q, chg_d;
  logic [N_CH-1:0]     loss_mask_q, loss_mask_d;
  logic                chg_mask_q, chg_mask_d;
  logic [31:0]         scratch_q, scratch_d;
  logic [CNT_W-1:0]    snap_q [N_CH];
  logic [CNT_W-1:0]    snap_d [N_CH];
  logic [31:0]         rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                err_q, err_d;
  logic [31:0]         rd_val;
  logic                mapped;

  always_comb begin
    fallback_d  = fallback_q;
    manual_d    = manual_q;
    mchan_d     = mchan_q;
    prio_d      = prio_q;
    timer_d     = timer_q;
    loss_d      = loss_q;
    chg_d       = chg_q;
    loss_mask_d = loss_mask_q;
    chg_mask_d  = chg_mask_q;
    scratch_d   = scratch_q;
    snap_d      = snap_q;
    rd_val      = '0;
    mapped      = 1'b0;

    case (mm_addr)
      ADDR_CTRL: begin
        mapped         = 1'b1;
        rd_val[0]      = fallback_q;
        rd_val[1]      = manual_q;
        rd_val[4+:CHW] = mchan_q;
      end
      ADDR_PRIO: begin
        mapped                  = 1'b1;
        rd_val[N_CH*CHW-1:0]    = prio_q;
      end
      ADDR_TIMER: begin
        mapped                  = 1'b1;
        rd_val[TIMER_W-1:0]     = timer_q;
      end
      ADDR_STATUS: begin
        mapped            = 1'b1;
        rd_val[CHW-1:0]   = ac_q;
        rd_val[8+:N_CH]   = sp_q;
      end
      ADDR_IRQ_ST: begin
        mapped            = 1'b1;
        rd_val[N_CH-1:0]  = loss_q;
        rd_val[16]        = chg_q;
      end
      ADDR_IRQ_MSK: begin
        mapped            = 1'b1;
        rd_val[N_CH-1:0]  = loss_mask_q;
        rd_val[16]        = chg_mask_q;
      end
      ADDR_SCRATCH: begin
        mapped = 1'b1;
        rd_val = scratch_q;
      end
      ADDR_VERSION: begin
        mapped = 1'b1;
        rd_val = VERSION;
      end
      ADDR_CMD: mapped = 1'b1;
      default: ;
    endcase
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (mm_addr == 8'(16 + i)) begin
        mapped = 1'b1;
        rd_val = 32'(snap_q[i]);
      end
    end

    if (mm_write_en) begin
      case (mm_addr)
        ADDR_CTRL: begin
          fallback_d = mm_wdata[0];
          manual_d   = mm_wdata[1];
          if (32'(mm_wdata[4+:CHW]) < 32'(N_CH)) mchan_d = mm_wdata[4+:CHW];
        end
        ADDR_PRIO:    prio_d    = mm_wdata[N_CH*CHW-1:0];
        ADDR_TIMER:   timer_d   = mm_wdata[TIMER_W-1:0];
        ADDR_IRQ_ST: begin
          loss_d = loss_q & ~mm_wdata[N_CH-1:0];
          chg_d  = chg_q & ~mm_wdata[16];
        end
        ADDR_IRQ_MSK: begin
          loss_mask_d = mm_wdata[N_CH-1:0];
          chg_mask_d  = mm_wdata[16];
        end
        ADDR_SCRATCH: scratch_d = mm_wdata;
        ADDR_CMD: begin
          if (mm_wdata[0]) begin
            for (int unsigned i = 0; i < N_CH; i++) snap_d[i] = error_count[i*CNT_W +: CNT_W];
          end
        end
        default: ;
      endcase
    end

    // Events are OR-ed in after the W1C clear so a same-edge set wins.
    loss_d = loss_d | (sp_q & ~signal_present);
    if (armed_q && (ac_q != active_channel)) chg_d = 1'b1;

    sp_d     = signal_present;
    ac_d     = active_channel;
    armed_d  = 1'b1;
    rvalid_d = mm_read_en;
    rdata_d  = mm_read_en ? rd_val : rdata_q;
    err_d    = (mm_read_en | mm_write_en) & ~mapped;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fallback_q  <= 1'b0;
      manual_q    <= 1'b0;
      mchan_q     <= '0;
      prio_q      <= '0;
      timer_q     <= '0;
      sp_q        <= '0;
      ac_q        <= '0;
      armed_q     <= 1'b0;
      loss_q      <= '0;
      chg_q       <= 1'b0;
      loss_mask_q <= '0;
      chg_mask_q  <= 1'b0;
      scratch_q   <= '0;
      for (int unsigned i = 0; i < N_CH; i++) snap_q[i] <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      fallback_q  <= fallback_d;
      manual_q    <= manual_d;
      mchan_q     <= mchan_d;
      prio_q      <= prio_d;
      timer_q     <= timer_d;
      sp_q        <= sp_d;
      ac_q        <= ac_d;
      armed_q     <= armed_d;
      loss_q      <= loss_d;
      chg_q       <= chg_d;
      loss_mask_q <= loss_mask_d;
      chg_mask_q  <= chg_mask_d;
      scratch_q   <= scratch_d;
      snap_q      <= snap_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
    end
  end

  assign mm_rdata         = rdata_q;
  assign mm_rvalid        = rvalid_q;
  assign mm_err           = err_q;
  assign fallback_enable  = fallback_q;
  assign manual_enable    = manual_q;
  assign manual_channel   = mchan_q;
  assign channel_priority = prio_q;
  assign reset_timer      = timer_q;
  assign irq              = (|(loss_q & loss_mask_q)) | (chg_q & chg_mask_q);

endmodule

// File: tb/tb_qos_csr_bank.sv
// Randomised and directed bench for qos_csr_bank against a register-map level reference model.
module tb_qos_csr_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata, rdata3;
  logic        rvalid, err, irq, rvalid3, err3, irq3;
  logic        fb, man, fb3, man3;
  logic [1:0]  mch, mch3;
  logic [7:0]  prio;
  logic [5:0]  prio3;
  logic [19:0] timer, timer3;
  logic [1:0]  ac = 2'd0;
  logic [3:0]  sp = '0;
  logic [31:0] ec = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  qos_csr_bank #(.N_CH(4), .CNT_W(8), .TIMER_W(20), .VERSION(32'h0002_0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .mm_write_en(wr_en), .mm_read_en(rd_en), .mm_addr(addr),
    .mm_wdata(wdata), .mm_rdata(rdata), .mm_rvalid(rvalid), .mm_err(err),
    .fallback_enable(fb), .manual_enable(man), .manual_channel(mch),
    .channel_priority(prio), .reset_timer(timer), .irq(irq),
    .active_channel(ac), .signal_present(sp), .error_count(ec)
  );

  qos_csr_bank #(.N_CH(3), .CNT_W(8), .TIMER_W(20), .VERSION(32'h0002_0000)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mm_write_en(wr_en), .mm_read_en(rd_en), .mm_addr(addr),
    .mm_wdata(wdata), .mm_rdata(rdata3), .mm_rvalid(rvalid3), .mm_err(err3),
    .fallback_enable(fb3), .manual_enable(man3), .manual_channel(mch3),
    .channel_priority(prio3), .reset_timer(timer3), .irq(irq3),
    .active_channel(ac), .signal_present(sp[2:0]), .error_count(ec[23:0])
  );

  // Reference model state for the 4-channel instance (plus CTRL channel field of the 3-channel one)
  bit          m_fb, m_man, m_armed, m_rvalid, m_err;
  int unsigned m_mch, m3_mch;
  logic [31:0] m_prio, m_timer, m_scratch, m_irqs, m_mask, m_rdata;
  logic [31:0] m_snap [4];
  logic [3:0]  m_sp;
  logic [1:0]  m_ac;

  task automatic model_reset();
    m_fb = 0; m_man = 0; m_armed = 0; m_rvalid = 0; m_err = 0;
    m_mch = 0; m3_mch = 0;
    m_prio = 0; m_timer = 0; m_scratch = 0; m_irqs = 0; m_mask = 0; m_rdata = 0;
    for (int i = 0; i < 4; i++) m_snap[i] = 0;
    m_sp = 0; m_ac = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] a);
    case (a)
      8'h00: return (32'(m_mch) << 4) | (32'(m_man) << 1) | 32'(m_fb);
      8'h01: return m_prio;
      8'h02: return m_timer;
      8'h03: return 32'(m_ac) | (32'(m_sp) << 8);
      8'h04: return m_irqs;
      8'h05: return m_mask;
      8'h06: return m_scratch;
      8'h07: return 32'h0002_0000;
      8'h10, 8'h11, 8'h12, 8'h13: return m_snap[int'(a) - 16];
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit model_mapped(input logic [7:0] a);
    return (a <= 8'h08) || (a >= 8'h10 && a < 8'h14);
  endfunction

  function automatic bit model_irq();
    return (m_irqs & m_mask) != 0;
  endfunction

  // Advance one clock: update the model from the inputs being presented, then sample DUT at edge+1
  task automatic tick();
    logic [31:0] rv, ev;
    int unsigned fld;
    rv = model_read(addr);
    ev = 0;
    for (int i = 0; i < 4; i++) if (m_sp[i] && !sp[i]) ev[i] = 1'b1;
    if (m_armed && m_ac != ac) ev[16] = 1'b1;
    if (wr_en) begin
      case (addr)
        8'h00: begin
          m_fb = wdata[0]; m_man = wdata[1];
          fld = (wdata >> 4) & 3;
          m_mch = fld;
          if (fld < 3) m3_mch = fld;
        end
        8'h01: m_prio = wdata & 32'hFF;
        8'h02: m_timer = wdata & 32'hF_FFFF;
        8'h04: m_irqs = m_irqs & ~wdata;
        8'h05: m_mask = wdata & 32'h1_000F;
        8'h06: m_scratch = wdata;
        8'h08: if (wdata[0]) for (int i = 0; i < 4; i++) m_snap[i] = (ec >> (8 * i)) & 32'hFF;
        default: ;
      endcase
    end
    m_irqs = m_irqs | ev;
    m_rvalid = rd_en;
    if (rd_en) m_rdata = rv;
    m_err = (rd_en || wr_en) && !model_mapped(addr);
    m_sp = sp; m_ac = ac; m_armed = 1;
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a);
    addr = a; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ac = 2'd2; sp = '0; ec = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rdata, rvalid, err, irq} !== '0) begin
      failures++; $display("FAIL reset_bus: got rdata=%h rvalid=%b err=%b irq=%b, expected all 0", rdata, rvalid, err, irq);
    end
    checks++;
    if ({fb, man, mch, prio, timer} !== '0) begin
      failures++; $display("FAIL reset_cfg: got fb=%b man=%b mch=%0d prio=%h timer=%h, expected all 0", fb, man, mch, prio, timer);
    end
    checks++;
    if ({irq3, prio3, timer3, mch3} !== '0) begin
      failures++; $display("FAIL reset_cfg3: got irq=%b prio=%h timer=%h mch=%0d, expected 0", irq3, prio3, timer3, mch3);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (2) tick();
    do_read(8'h07);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h0002_0000) begin
      failures++; $display("FAIL version_read: got rvalid=%b rdata=%h, expected 1 00020000", rvalid, rdata);
    end
    tick();
    checks++;
    if (rvalid !== 1'b0 || rdata !== 32'h0002_0000) begin
      failures++; $display("FAIL rvalid_fall: got rvalid=%b rdata=%h, expected 0 00020000", rvalid, rdata);
    end
    do_read(8'h00);
    checks++;
    if (rdata !== 32'h0) begin
      failures++; $display("FAIL ctrl_reset_read: got %h expected 0", rdata);
    end
    do_read(8'h04);
    checks++;
    if (rdata !== 32'h0) begin
      failures++; $display("FAIL no_spurious_chg: got %h expected 0", rdata);
    end
    ac = 2'd1;
    tick();
    do_read(8'h04);
    checks++;
    if (rdata !== 32'h0001_0000 || rdata !== m_rdata) begin
      failures++; $display("FAIL chg_flag: got %h expected 00010000", rdata);
    end
    do_read(8'h03);
    checks++;
    if (rdata !== 32'h0000_0001) begin
      failures++; $display("FAIL status_mirror: got %h expected 00000001", rdata);
    end
  endtask

  task automatic test_ctrl();
    do_write(8'h00, 32'h0000_0033);
    checks++;
    if (fb !== 1'b1 || man !== 1'b1 || mch !== 2'd3) begin
      failures++; $display("FAIL ctrl4_33: got fb=%b man=%b mch=%0d expected 1 1 3", fb, man, mch);
    end
    checks++;
    if (fb3 !== 1'b1 || man3 !== 1'b1 || mch3 !== 2'd0) begin
      failures++; $display("FAIL ctrl3_out_of_range: got fb=%b man=%b mch=%0d expected 1 1 0", fb3, man3, mch3);
    end
    do_write(8'h00, 32'h0000_0022);
    checks++;
    if (fb3 !== 1'b0 || man3 !== 1'b1 || mch3 !== 2'(m3_mch) || mch3 !== 2'd2) begin
      failures++; $display("FAIL ctrl3_22: got fb=%b man=%b mch=%0d expected 0 1 2", fb3, man3, mch3);
    end
    do_read(8'h00);
    checks++;
    if (rdata !== 32'h22 || rdata3 !== 32'h22 || rvalid3 !== 1'b1 || err3 !== 1'b0) begin
      failures++; $display("FAIL ctrl_readback: got %h / %h rvalid3=%b err3=%b expected 22 / 22 1 0", rdata, rdata3, rvalid3, err3);
    end
  endtask

  task automatic test_irq_loss();
    do_write(8'h04, 32'h0001_000F);
    do_write(8'h05, 32'h0001_0001);
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL irq_idle: got %b expected 0", irq);
    end
    sp[0] = 1'b1;
    repeat (3) tick();
    sp[0] = 1'b0;
    tick();
    checks++;
    if (irq !== 1'b1) begin
      failures++; $display("FAIL irq_loss_rise: got %b expected 1", irq);
    end
    do_read(8'h04);
    checks++;
    if (rdata !== 32'h1) begin
      failures++; $display("FAIL loss_flag: got %h expected 00000001", rdata);
    end
    sp[0] = 1'b1;
    tick();
    sp[0] = 1'b0;
    do_write(8'h04, 32'h1);
    do_read(8'h04);
    checks++;
    if (rdata !== 32'h1 || irq !== 1'b1) begin
      failures++; $display("FAIL set_beats_clear: got flags=%h irq=%b expected 00000001 1", rdata, irq);
    end
    do_write(8'h04, 32'h1);
    checks++;
    if (irq !== 1'b0 || irq !== model_irq()) begin
      failures++; $display("FAIL irq_clear: got %b expected 0", irq);
    end
    sp[1] = 1'b1; tick(); sp[1] = 1'b0; tick();
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL irq_masked: got %b expected 0", irq);
    end
  endtask

  task automatic test_snapshot();
    ec = {8'd8, 8'd7, 8'd6, 8'd5};
    do_write(8'h08, 32'h1);
    ec = 32'h0909_0909;
    for (int i = 0; i < 4; i++) begin
      do_read(8'(16 + i));
      checks++;
      if (rdata !== 32'(5 + i)) begin
        failures++; $display("FAIL snap_ch%0d: got %h expected %h", i, rdata, 32'(5 + i));
      end
    end
    do_read(8'h08);
    checks++;
    if (rdata !== 32'h0 || err !== 1'b0) begin
      failures++; $display("FAIL cmd_read: got %h err=%b expected 0 0", rdata, err);
    end
  endtask

  task automatic test_unmapped();
    do_read(8'h14);
    checks++;
    if (rdata !== 32'h0 || rvalid !== 1'b1 || err !== 1'b1) begin
      failures++; $display("FAIL unmapped_read: got rdata=%h rvalid=%b err=%b expected 0 1 1", rdata, rvalid, err);
    end
    tick();
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL err_pulse: got %b expected 0", err);
    end
    do_write(8'h06, 32'hCAFE_F00D);
    do_write(8'h40, 32'h1234_5678);
    checks++;
    if (err !== 1'b1) begin
      failures++; $display("FAIL unmapped_write: got err=%b expected 1", err);
    end
    do_write(8'h07, 32'hFFFF_FFFF);
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL ro_write_silent: got err=%b expected 0", err);
    end
    do_read(8'h06);
    checks++;
    if (rdata !== 32'hCAFE_F00D) begin
      failures++; $display("FAIL scratch_intact: got %h expected cafef00d", rdata);
    end
  endtask

  task automatic test_back_to_back();
    addr = 8'h06; wdata = 32'h0BAD_BEEF; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    checks++;
    if (rdata !== 32'hCAFE_F00D) begin
      failures++; $display("FAIL rd_wr_same_addr: got %h expected cafef00d", rdata);
    end
    wr_en = 1'b0; addr = 8'h06;
    tick();
    rd_en = 1'b0;
    checks++;
    if (rdata !== 32'h0BAD_BEEF || rvalid !== 1'b1) begin
      failures++; $display("FAIL b2b_read: got %h rvalid=%b expected 0badbeef 1", rdata, rvalid);
    end
  endtask

  task automatic test_random();
    logic [7:0] addrs [16];
    addrs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
              8'h08, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h40, 8'h09};
    for (int n = 0; n < 400; n++) begin
      rd_en = 1'($urandom % 2);
      wr_en = ($urandom % 3) == 0;
      addr  = addrs[$urandom % 16];
      wdata = $urandom;
      if ($urandom % 4 == 0) sp = sp ^ (4'b1 << ($urandom % 4));
      if ($urandom % 10 == 0) ac = 2'($urandom % 4);
      ec = $urandom;
      tick();
      checks++;
      if (rvalid !== m_rvalid || err !== m_err) begin
        failures++; $display("FAIL rnd_handshake[%0d]: got rvalid=%b err=%b expected %b %b", n, rvalid, err, m_rvalid, m_err);
      end
      checks++;
      if (rdata !== m_rdata) begin
        failures++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", n, rdata, m_rdata);
      end
      checks++;
      if (irq !== model_irq()) begin
        failures++; $display("FAIL rnd_irq[%0d]: got %b expected %b", n, irq, model_irq());
      end
      checks++;
      if (fb !== m_fb || man !== m_man || mch !== 2'(m_mch)) begin
        failures++; $display("FAIL rnd_ctrl[%0d]: got %b %b %0d expected %b %b %0d", n, fb, man, mch, m_fb, m_man, m_mch);
      end
      checks++;
      if (prio !== m_prio[7:0] || timer !== m_timer[19:0]) begin
        failures++; $display("FAIL rnd_cfg[%0d]: got prio=%h timer=%h expected %h %h", n, prio, timer, m_prio[7:0], m_timer[19:0]);
      end
    end
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_reset_midread();
    do_write(8'h02, 32'h000A_BCDE);
    addr = 8'h07; rd_en = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rvalid !== 1'b0 || rdata !== 32'h0 || timer !== 20'h0) begin
      failures++; $display("FAIL reset_midread: got rvalid=%b rdata=%h timer=%h expected 0 0 0", rvalid, rdata, timer);
    end
    rd_en = 1'b0;
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_read(8'h02);
    checks++;
    if (rdata !== 32'h0 || rvalid !== 1'b1) begin
      failures++; $display("FAIL timer_after_reset: got %h rvalid=%b expected 0 1", rdata, rvalid);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ctrl();
    test_irq_loss();
    test_snapshot();
    test_unmapped();
    test_back_to_back();
    test_random();
    test_reset_midread();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
